// File: rtl/radio_interference_gen.sv
// radio_interference_gen: NUM_CH independent interference channels (off, fixed
// tone, frequency sweep, LFSR noise) whose square waves are summed and turned
// into one 1-bit PDM stream by a first-order sigma-delta mixer.
module radio_interference_gen #(
  parameter int          NUM_CH     = 2,
  parameter int          DIV_W      = 16,
  parameter int          TONE_DIV   = 25000,
  parameter int          SWEEP_MIN  = 10000,
  parameter int          SWEEP_MAX  = 50000,
  parameter int          SWEEP_STEP = 1000,
  parameter int          NOISE_DIV  = 50,
  parameter logic [15:0] SEED       = 16'hACE1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [2*NUM_CH-1:0] mode,
  output logic [NUM_CH-1:0]   ch_out,
  output logic                out
);

  localparam int SUM_W = $clog2(NUM_CH + 1);
  localparam int ACC_W = $clog2(NUM_CH) + 1;
  localparam int T_W   = SUM_W + ACC_W;

  localparam logic [DIV_W-1:0] TONE_LAST  = DIV_W'(TONE_DIV - 1);
  localparam logic [DIV_W-1:0] NOISE_LAST = DIV_W'(NOISE_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_MIN    = DIV_W'(SWEEP_MIN);
  // Sweep arithmetic is done one bit wider so the step can never wrap.
  localparam logic [DIV_W:0]   STEP_EXT   = (DIV_W+1)'(SWEEP_STEP);
  localparam logic [DIV_W:0]   MAX_EXT    = (DIV_W+1)'(SWEEP_MAX);
  localparam logic [T_W-1:0]   NUM_CH_T   = T_W'(NUM_CH);

  // One Fibonacci step (taps 16,14,13,11); an all-zero register reloads its seed.
  function automatic logic [15:0] lfsr_step(input logic [15:0] l, input logic [15:0] seed);
    logic [15:0] r;
    if (l == 16'h0000) begin
      r = seed;
    end else begin
      r = {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    end
    return r;
  endfunction

  // Number of channels currently high.
  function automatic logic [SUM_W-1:0] popcount(input logic [NUM_CH-1:0] v);
    logic [SUM_W-1:0] c;
    c = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      c = c + SUM_W'(v[k]);
    end
    return c;
  endfunction

  for (genvar i = 0; i < NUM_CH; i++) begin : gen_ch
    localparam logic [15:0] SEED_RAW = SEED ^ 16'(i);
    localparam logic [15:0] CH_SEED  = (SEED_RAW == 16'h0000) ? 16'h0001 : SEED_RAW;

    logic [1:0]       mode_in;
    logic [1:0]       mode_q;
    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] cnt_n;
    logic [DIV_W-1:0] cur_div;
    logic [DIV_W-1:0] cur_div_n;
    logic [DIV_W:0]   div_sum;
    logic             sq;
    logic             sq_n;
    logic [15:0]      lfsr;
    logic [15:0]      lfsr_n;
    logic             wave;
    logic             wave_n;
    logic             restart;

    assign mode_in   = mode[2*i +: 2];
    assign restart   = (mode_in != mode_q);
    assign div_sum   = {1'b0, cur_div} + STEP_EXT;
    assign ch_out[i] = wave;

    // Next-state logic: a mode change restarts the channel, else the captured mode counts.
    always_comb begin
      cnt_n     = cnt;
      sq_n      = sq;
      cur_div_n = cur_div;
      lfsr_n    = lfsr;
      if (restart) begin
        cnt_n     = '0;
        sq_n      = 1'b0;
        cur_div_n = DIV_MIN;
        lfsr_n    = CH_SEED;
      end else begin
        case (mode_q)
          2'd0: begin
            cnt_n = '0;
          end
          2'd1: begin
            if (cnt == TONE_LAST) begin
              cnt_n = '0;
              sq_n  = ~sq;
            end else begin
              cnt_n = cnt + DIV_W'(1);
            end
          end
          2'd2: begin
            if (cnt == cur_div - DIV_W'(1)) begin
              cnt_n = '0;
              sq_n  = ~sq;
              // The period only grows on the falling toggle, so both halves match.
              if (sq) begin
                cur_div_n = (div_sum > MAX_EXT) ? DIV_MIN : div_sum[DIV_W-1:0];
              end else begin
                cur_div_n = cur_div;
              end
            end else begin
              cnt_n = cnt + DIV_W'(1);
            end
          end
          2'd3: begin
            if (cnt == NOISE_LAST) begin
              cnt_n  = '0;
              lfsr_n = lfsr_step(lfsr, CH_SEED);
            end else begin
              cnt_n = cnt + DIV_W'(1);
            end
          end
          default: begin
            cnt_n = '0;
          end
        endcase
      end
      // The waveform reflects the state being loaded on this edge under the new mode.
      case (mode_in)
        2'd1:    wave_n = sq_n;
        2'd2:    wave_n = sq_n;
        2'd3:    wave_n = lfsr_n[0];
        default: wave_n = 1'b0;
      endcase
    end

    // Channel state and registered waveform output.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        mode_q  <= 2'd0;
        cnt     <= '0;
        sq      <= 1'b0;
        cur_div <= DIV_MIN;
        lfsr    <= CH_SEED;
        wave    <= 1'b0;
      end else begin
        mode_q  <= mode_in;
        cnt     <= cnt_n;
        sq      <= sq_n;
        cur_div <= cur_div_n;
        lfsr    <= lfsr_n;
        wave    <= wave_n;
      end
    end
  end

  logic [ACC_W-1:0] acc;
  logic [SUM_W-1:0] sum;
  logic [T_W-1:0]   t;

  // Mixer input: running accumulator plus the number of active channels.
  always_comb begin
    sum = popcount(ch_out);
    t   = T_W'(acc) + T_W'(sum);
  end

  // First-order sigma-delta: emit a 1 whenever the accumulator reaches NUM_CH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
      out <= 1'b0;
    end else if (t >= NUM_CH_T) begin
      acc <= ACC_W'(t - NUM_CH_T);
      out <= 1'b1;
    end else begin
      acc <= ACC_W'(t);
      out <= 1'b0;
    end
  end

endmodule

// File: tb/tb_radio_interference_gen.sv
// Directed bench for radio_interference_gen with small dividers so every
// mode completes several periods in a few hundred cycles.
module tb_radio_interference_gen;

  logic       clk;
  logic       rst_n;
  logic [3:0] mode;
  logic [1:0] ch_out;
  logic       out;

  int n_checks = 0;
  int n_pass   = 0;

  // Expected mixer state, driven by the expected channel outputs.
  logic [1:0] prev_ch = 2'b00;
  logic [1:0] m_acc   = 2'd0;

  radio_interference_gen #(
    .NUM_CH(2), .DIV_W(16), .TONE_DIV(4), .SWEEP_MIN(2), .SWEEP_MAX(6),
    .SWEEP_STEP(2), .NOISE_DIV(3), .SEED(16'hACE1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .ch_out(ch_out), .out(out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  function automatic logic [15:0] lfsr_model(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  // Advance one clock and compare channel outputs and the mixer bit.
  task automatic step_check(input string tag, input logic [1:0] exp_ch);
    logic [2:0] tt;
    logic       exp_out;
    tt = {1'b0, m_acc} + {2'b00, prev_ch[0]} + {2'b00, prev_ch[1]};
    if (tt >= 3'd2) begin
      exp_out = 1'b1;
      m_acc   = 2'(tt - 3'd2);
    end else begin
      exp_out = 1'b0;
      m_acc   = tt[1:0];
    end
    @(posedge clk);
    #1;
    check_val({tag, "_ch"}, {14'd0, ch_out}, {14'd0, exp_ch});
    check_val({tag, "_out"}, {15'd0, out}, {15'd0, exp_out});
    prev_ch = exp_ch;
  endtask

  initial begin
    logic [15:0] l0;
    logic [15:0] l1;
    int          mc;
    int          half [8];
    int          next_t;
    int          idx;
    logic        sq;
    logic        b0;
    logic        b1;
    logic [1:0]  post_rst [6];

    // Reset held with all channels requesting noise.
    rst_n   = 1'b0;
    mode    = 4'b1111;
    #2;
    check_val("rst_async_ch", {14'd0, ch_out}, 16'd0);
    check_val("rst_async_out", {15'd0, out}, 16'd0);
    for (int k = 0; k < 5; k++) begin
      step_check("reset", 2'b00);
    end
    rst_n = 1'b1;

    // Noise on both channels: restart on first edge, shift every 3 edges.
    l0 = 16'hACE1;
    l1 = 16'hACE0;
    mc = 0;
    for (int r = 0; r < 30; r++) begin
      if (r > 0) begin
        if (mc == 2) begin
          mc = 0;
          l0 = lfsr_model(l0);
          l1 = lfsr_model(l1);
        end else begin
          mc++;
        end
      end
      step_check("noise", {l1[0], l0[0]});
      if (r == 0) check_val("lfsr_seed", dut.gen_ch[0].lfsr, 16'hACE1);
      if (r == 3) check_val("lfsr_1st", dut.gen_ch[0].lfsr, 16'h59C3);
      if (r == 6) check_val("lfsr_2nd", dut.gen_ch[0].lfsr, 16'hB387);
    end

    // Tone on channel 0 only: half-period 4, rises on the 4th edge.
    mode = 4'b0001;
    for (int r = 0; r < 20; r++) begin
      b0 = ((r / 4) % 2) == 1;
      step_check("tone", {1'b0, b0});
    end

    // Sweep on channel 0: half-periods 2,2,4,4,6,6,2,2.
    mode    = 4'b0010;
    half[0] = 2; half[1] = 2; half[2] = 4; half[3] = 4;
    half[4] = 6; half[5] = 6; half[6] = 2; half[7] = 2;
    sq      = 1'b0;
    idx     = 0;
    next_t  = half[0];
    for (int r = 0; r <= 28; r++) begin
      if (r > 0 && r == next_t) begin
        sq = ~sq;
        idx++;
        if (idx < 8) next_t = next_t + half[idx];
      end
      step_check("sweep", {1'b0, sq});
    end

    // Both channels in tone mode: identical waves, out follows 11/00.
    mode = 4'b0101;
    for (int r = 0; r < 19; r++) begin
      b0 = ((r / 4) % 2) == 1;
      step_check("both", {b0, b0});
    end

    // Channel 0 switches to sweep with cnt=2; channel 1 keeps its tone.
    mode = 4'b0110;
    step_check("midsw", 2'b00);
    check_val("midsw_div", dut.gen_ch[0].cur_div, 16'd2);
    check_val("midsw_cnt", dut.gen_ch[0].cnt, 16'd0);
    step_check("midsw", 2'b10);
    step_check("midsw", 2'b11);

    // Asynchronous reset in the middle of a cycle clears outputs at once.
    #2;
    rst_n = 1'b0;
    #1;
    check_val("arst_ch", {14'd0, ch_out}, 16'd0);
    check_val("arst_out", {15'd0, out}, 16'd0);
    check_val("arst_div", dut.gen_ch[0].cur_div, 16'd2);
    prev_ch = 2'b00;
    m_acc   = 2'd0;
    step_check("arst_hold", 2'b00);
    rst_n = 1'b1;

    // Clean restart: ch0 sweep (half 2), ch1 tone (half 4).
    post_rst[0] = 2'b00; post_rst[1] = 2'b00; post_rst[2] = 2'b01;
    post_rst[3] = 2'b01; post_rst[4] = 2'b10; post_rst[5] = 2'b10;
    for (int r = 0; r < 6; r++) begin
      step_check("post_rst", post_rst[r]);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/radio_interference_gen.md
Name: radio_interference_gen

Overview:
- Parametrised multi-channel successor to the single-output radio interface: NUM_CH independent channels, each with its own 2-bit mode (off / fixed tone / frequency sweep / LFSR noise).
- Channel square waves are summed and converted to one 1-bit PDM stream by a first-order sigma-delta mixer.
- Drives the board speaker/antenna pin from the top level; per-channel raw outputs are exported for LEDs and debug.

Parameters:
- NUM_CH, 2, number of channels (1..8).
- DIV_W, 16, width of divider counters; must hold SWEEP_MAX+SWEEP_STEP, TONE_DIV and NOISE_DIV.
- TONE_DIV, 25000, mode-1 half-period in clk cycles (≥1).
- SWEEP_MIN, 10000, mode-2 starting half-period (≥1).
- SWEEP_MAX, 50000, mode-2 largest half-period (≥SWEEP_MIN).
- SWEEP_STEP, 1000, half-period increment per full sweep period.
- NOISE_DIV, 50, clk cycles per LFSR shift in mode 3 (≥1).
- SEED, 16'hACE1, LFSR seed base.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- mode  input  2*NUM_CH  channel i mode = mode[2i+1:2i]: 0 off, 1 tone, 2 sweep, 3 noise.
- ch_out  output  NUM_CH  registered per-channel waveform.
- out  output  1  registered PDM mixer output.

Behaviour:
- Reset (rst_n=0, async): out=0, ch_out=0, mode_q=0, all counters=0, cur_div=SWEEP_MIN, LFSR_i=SEED^i (forced to 16'h0001 if zero), mixer acc=0. Reset may assert at any cycle; the block then restarts cleanly.
- Mode capture: mode_q<=mode every edge. Restart for channel i when mode_i != mode_q_i at an edge. On that same edge:
  - cnt=0, sq=0, cur_div=SWEEP_MIN, LFSR reloaded to seed.
  - The new mode governs counting from the next edge.
- Mode 0: cnt held 0; ch_out=0.
- Mode 1:
  - cnt increments each edge; when cnt==TONE_DIV-1, cnt<=0 and sq toggles.
  - Result: 50% square wave, period 2*TONE_DIV; first rising edge on the TONE_DIV-th edge after restart.
- Mode 2:
  - Same as mode 1, with terminal value cur_div-1.
  - On each 1->0 toggle of sq: cur_div <= cur_div+SWEEP_STEP, or SWEEP_MIN if that sum exceeds SWEEP_MAX. Compute the sum in DIV_W+1 bits; no overflow allowed.
  - New cur_div applies from the next half-period.
- Mode 3:
  - Noise counter 0..NOISE_DIV-1; at terminal count, 16-bit Fibonacci LFSR shifts left with bit0 <= l[15]^l[13]^l[12]^l[10].
  - ch_out_i = LFSR[0]; immediately after restart this equals the seed bit 0.
  - If the LFSR ever reads 0, it reloads the seed on the next shift.
- ch_out_i = sq_i in modes 1/2, LFSR_i[0] in mode 3, 0 in mode 0; registered (updates on the edge the state changes).
- Mixer, per edge:
  - sum = popcount(ch_out), width $clog2(NUM_CH+1).
  - t = acc+sum. If t ≥ NUM_CH: out<=1, acc<=t-NUM_CH; else out<=0, acc<=t.
  - Long-run density of out = sum/NUM_CH; out lags ch_out by one cycle.
  - acc stays below NUM_CH, so width $clog2(NUM_CH)+1 suffices.
- Channels are fully independent. A restart on one channel does not affect other channels or acc.

Test Plan:
Bench parameters: NUM_CH=2, TONE_DIV=4, SWEEP_MIN=2, SWEEP_MAX=6, SWEEP_STEP=2, NOISE_DIV=3.
- Reset: rst_n=0 for 5 cycles with mode=4'b1111 -> out=0, ch_out=2'b00 throughout; release -> restart occurs on the first edge.
- Tone: mode=4'b0001 -> ch_out[0] rises 4 edges after restart edge, period 8, 50% duty; ch_out[1]=0; while ch_out[0]=1, out alternates 0,1,0,1 (density 1/2).
- Sweep: ch0 mode 2 -> successive half-periods 2,2,4,4,6,6,2,2 (full periods 4,8,12,4, wrapping because 8>6).
- Noise: ch0 mode 3 -> LFSR ACE1, then 59C3 after 3 cycles, then B387 after 3 more; ch_out[0]=1,1,1; ch1 mode 3 seed ACE0 gives ch_out[1]=0 initially.
- Both tone: mode=4'b0101 -> ch_out identical; out=1 on every cycle where the prior ch_out=2'b11, 0 where 2'b00.
- Mid-operation: switch ch0 1->2 at cnt=2, then assert rst_n=0 asynchronously mid-cycle -> restart on the mode-change edge (ch_out[0]=0, cur_div=2); all outputs 0 immediately on reset without waiting for clk.
